// File: rtl/btn_pkg.sv
// Shared button constants, event layout and debouncer timing for the button event path.
package btn_pkg;

   localparam int unsigned BTN_LEFT  = 0;
   localparam int unsigned BTN_RIGHT = 1;
   localparam int unsigned BTN_UP    = 2;
   localparam int unsigned BTN_DOWN  = 3;

   localparam int unsigned N_BTN_DEF      = 4;
   localparam int unsigned FIFO_DEPTH_DEF = 8;
   localparam int unsigned BTN_ID_W       = 2;

   // Queue entry layout: {repeat, id}
   typedef struct packed {
      logic                rep;
      logic [BTN_ID_W-1:0] id;
   } btn_evt_t;

   // Debouncer timing, in clk cycles
   localparam int unsigned DEB_SETTLE_CYC = 3;
   localparam int unsigned REP_DELAY_CYC  = 2;
   localparam int unsigned REP_PERIOD_CYC = 2;

endpackage

// File: rtl/btn_sync_fifo.sv
// Generic synchronous FIFO; pointers wrap modulo DEPTH, full push allowed alongside a pop.
module btn_sync_fifo #(
   parameter  int unsigned WIDTH = 3,
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             push_acc_c,
   output logic [WIDTH-1:0] rdata_c,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic             pop_acc;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      pop_acc    = pop && (count != '0);
      push_acc_c = push && ((count < CNT_W'(DEPTH)) || pop_acc);
      rdata_c    = mem[rptr];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_acc_c) wptr <= ptr_inc(wptr);
         if (pop_acc)    rptr <= ptr_inc(rptr);
         if (push_acc_c && !pop_acc)      count <= count + CNT_W'(1);
         else if (pop_acc && !push_acc_c) count <= count - CNT_W'(1);
      end
   end

   // Storage needs no reset: entries are only visible once counted
   always_ff @(posedge clk) begin
      if (push_acc_c) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/btn_event_queue.sv
// Tags debounced button pulses as press/repeat and queues them in arrival order.
module btn_event_queue
   import btn_pkg::*;
#(
   parameter  int unsigned N_BTN = N_BTN_DEF,
   parameter  int unsigned DEPTH = FIFO_DEPTH_DEF,
   localparam int unsigned ID_W  = (N_BTN > 1) ? $clog2(N_BTN) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned EVT_W = ID_W + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_BTN-1:0] btn_pulse,
   input  logic [N_BTN-1:0] btn_level,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [ID_W-1:0]  evt_id,
   output logic             evt_repeat,
   output logic [CNT_W-1:0] evt_count,
   output logic             overflow,
   input  logic             clear_overflow
);

   logic [N_BTN-1:0] held_seen;
   logic [N_BTN-1:0] pending;
   logic [N_BTN-1:0] pend_rep;
   logic [N_BTN-1:0] wr_onehot;
   logic [N_BTN-1:0] capture;
   logic [N_BTN-1:0] drop;
   logic [ID_W-1:0]  sel;
   logic             found;
   logic             push_acc;
   logic [EVT_W-1:0] wdata;
   logic [EVT_W-1:0] rdata;

   // Lowest-index pending button wins the single write slot
   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int i = 0; i < int'(N_BTN); i++) begin
         if (pending[i] && !found) begin
            sel   = ID_W'(i);
            found = 1'b1;
         end
      end
      wdata = {pend_rep[sel], sel};
   end

   // A button being written this cycle may capture a new pulse instead of dropping it
   always_comb begin
      wr_onehot = '0;
      if (push_acc) wr_onehot[sel] = 1'b1;
      capture = btn_pulse & (~pending | wr_onehot);
      drop    = btn_pulse & pending & ~wr_onehot;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         held_seen <= '0;
         pending   <= '0;
         pend_rep  <= '0;
         overflow  <= 1'b0;
      end else begin
         held_seen <= btn_level & (held_seen | btn_pulse);
         pending   <= (pending & ~wr_onehot) | capture;
         pend_rep  <= (pend_rep & ~capture) | (capture & held_seen & btn_level);
         overflow  <= (|drop) | (overflow & ~clear_overflow);
      end
   end

   btn_sync_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (|pending),
      .wdata      (wdata),
      .pop        (evt_ready),
      .push_acc_c (push_acc),
      .rdata_c    (rdata),
      .count      (evt_count)
   );

   always_comb begin
      evt_valid  = (evt_count != '0);
      evt_id     = evt_valid ? rdata[ID_W-1:0] : '0;
      evt_repeat = evt_valid & rdata[ID_W];
   end

endmodule

// File: tb/tb_btn_event_queue.sv
// Directed vector bench for btn_event_queue: table of cycle vectors plus corner-case sequences.
module tb_btn_event_queue;
   import btn_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] btn_pulse;
   logic [3:0] btn_level;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_id;
   logic       evt_repeat;
   logic [3:0] evt_count;
   logic       overflow;
   logic       clear_overflow;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] pulse;
      logic [3:0] level;
      logic       ready;
      logic       clr;
      logic       valid;
      logic [1:0] id;
      logic       rep;
      logic [3:0] cnt;
      logic       ovf;
   } vec_t;

   vec_t     vecs[27];
   btn_evt_t exp_q[$];
   btn_evt_t ev;
   int       seq[8];

   btn_event_queue dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .btn_pulse      (btn_pulse),
      .btn_level      (btn_level),
      .evt_valid      (evt_valid),
      .evt_ready      (evt_ready),
      .evt_id         (evt_id),
      .evt_repeat     (evt_repeat),
      .evt_count      (evt_count),
      .overflow       (overflow),
      .clear_overflow (clear_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] p, input logic [3:0] l);
      btn_pulse = p;
      btn_level = l;
   endtask

   initial begin
      // pulse level rdy clr | valid id rep cnt ovf
      vecs[0]  = '{4'b0010, 4'b0010, 1, 0, 0, 2'd0, 0, 4'd0, 0};
      vecs[1]  = '{4'b0000, 4'b0010, 1, 0, 1, 2'd1, 0, 4'd1, 0};
      vecs[2]  = '{4'b0000, 4'b0010, 1, 0, 0, 2'd0, 0, 4'd0, 0};
      vecs[3]  = '{4'b0000, 4'b0000, 1, 0, 0, 2'd0, 0, 4'd0, 0};
      vecs[4]  = '{4'b0101, 4'b0101, 0, 0, 0, 2'd0, 0, 4'd0, 0};
      vecs[5]  = '{4'b0000, 4'b0101, 0, 0, 1, 2'd0, 0, 4'd1, 0};
      vecs[6]  = '{4'b0000, 4'b0101, 0, 0, 1, 2'd0, 0, 4'd2, 0};
      vecs[7]  = '{4'b0000, 4'b0101, 0, 0, 1, 2'd0, 0, 4'd2, 0};
      vecs[8]  = '{4'b0000, 4'b0101, 1, 0, 1, 2'd2, 0, 4'd1, 0};
      vecs[9]  = '{4'b0000, 4'b0101, 1, 0, 0, 2'd0, 0, 4'd0, 0};
      vecs[10] = '{4'b0000, 4'b0000, 0, 0, 0, 2'd0, 0, 4'd0, 0};
      vecs[11] = '{4'b1000, 4'b1000, 1, 0, 0, 2'd0, 0, 4'd0, 0};
      vecs[12] = '{4'b0000, 4'b1000, 1, 0, 1, 2'd3, 0, 4'd1, 0};
      vecs[13] = '{4'b1000, 4'b1000, 1, 0, 0, 2'd0, 0, 4'd0, 0};
      vecs[14] = '{4'b0000, 4'b1000, 1, 0, 1, 2'd3, 1, 4'd1, 0};
      vecs[15] = '{4'b1000, 4'b1000, 1, 0, 0, 2'd0, 0, 4'd0, 0};
      vecs[16] = '{4'b0000, 4'b1000, 1, 0, 1, 2'd3, 1, 4'd1, 0};
      vecs[17] = '{4'b0000, 4'b0000, 1, 0, 0, 2'd0, 0, 4'd0, 0};
      vecs[18] = '{4'b1000, 4'b1000, 1, 0, 0, 2'd0, 0, 4'd0, 0};
      vecs[19] = '{4'b0000, 4'b1000, 1, 0, 1, 2'd3, 0, 4'd1, 0};
      vecs[20] = '{4'b0000, 4'b0000, 1, 0, 0, 2'd0, 0, 4'd0, 0};
      vecs[21] = '{4'b0010, 4'b0010, 0, 0, 0, 2'd0, 0, 4'd0, 0};
      vecs[22] = '{4'b0010, 4'b0010, 0, 0, 1, 2'd1, 0, 4'd1, 0};
      vecs[23] = '{4'b0000, 4'b0010, 0, 0, 1, 2'd1, 0, 4'd2, 0};
      vecs[24] = '{4'b0000, 4'b0010, 1, 0, 1, 2'd1, 1, 4'd1, 0};
      vecs[25] = '{4'b0000, 4'b0010, 1, 0, 0, 2'd0, 0, 4'd0, 0};
      vecs[26] = '{4'b0000, 4'b0000, 0, 0, 0, 2'd0, 0, 4'd0, 0};

      reset_n        = 1'b0;
      btn_pulse      = '0;
      btn_level      = '0;
      evt_ready      = 1'b0;
      clear_overflow = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(evt_valid), 0);
      chk("rst_count", 32'(evt_count), 0);
      chk("rst_ovf",   32'(overflow), 0);
      chk("rst_id",    32'(evt_id), 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Table: single press, simultaneous pulses, hold/repeat, write+capture same button
      for (int i = 0; i < 27; i++) begin
         drive(vecs[i].pulse, vecs[i].level);
         evt_ready      = vecs[i].ready;
         clear_overflow = vecs[i].clr;
         tick();
         chk($sformatf("v%0d_valid", i), 32'(evt_valid), 32'(vecs[i].valid));
         chk($sformatf("v%0d_count", i), 32'(evt_count), 32'(vecs[i].cnt));
         chk($sformatf("v%0d_ovf", i),   32'(overflow),  32'(vecs[i].ovf));
         chk($sformatf("v%0d_id", i),    32'(evt_id),    32'(vecs[i].id));
         chk($sformatf("v%0d_rep", i),   32'(evt_repeat), 32'(vecs[i].rep));
      end

      // Fill to DEPTH with backpressure
      seq = '{BTN_RIGHT, BTN_UP, BTN_DOWN, BTN_RIGHT, BTN_UP, BTN_DOWN, BTN_RIGHT, BTN_UP};
      evt_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(4'(1 << seq[i]), 4'(1 << seq[i]));
         tick();
         ev.rep = 1'b0;
         ev.id  = 2'(seq[i]);
         exp_q.push_back(ev);
      end
      drive(4'b0000, 4'b0000);
      tick();
      chk("fill_count", 32'(evt_count), 8);
      chk("fill_ovf",   32'(overflow), 0);

      drive(4'b0001, 4'b0001);
      tick();
      drive(4'b0000, 4'b0000);
      chk("bp_count", 32'(evt_count), 8);
      chk("bp_ovf",   32'(overflow), 0);
      tick();
      chk("bp_hold_ovf", 32'(overflow), 0);
      ev.rep = 1'b0;
      ev.id  = 2'(BTN_LEFT);
      exp_q.push_back(ev);

      drive(4'b0001, 4'b0001);
      tick();
      chk("drop_ovf", 32'(overflow), 1);
      clear_overflow = 1'b1;
      tick();
      chk("drop_beats_clear", 32'(overflow), 1);
      drive(4'b0000, 4'b0000);
      tick();
      clear_overflow = 1'b0;
      chk("clear_ovf", 32'(overflow), 0);

      // Full: pop and pending write in the same cycle keep the count at DEPTH
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      void'(exp_q.pop_front());
      chk("full_pp_count", 32'(evt_count), 8);
      chk("full_pp_head",  32'(evt_id), 32'(exp_q[0].id));
      tick();
      chk("full_idle_count", 32'(evt_count), 8);

      evt_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain%0d_valid", i), 32'(evt_valid), 1);
         chk($sformatf("drain%0d_id", i),    32'(evt_id), 32'(exp_q[0].id));
         chk($sformatf("drain%0d_rep", i),   32'(evt_repeat), 32'(exp_q[0].rep));
         tick();
         void'(exp_q.pop_front());
      end
      evt_ready = 1'b0;
      chk("drain_count", 32'(evt_count), 0);
      chk("drain_valid", 32'(evt_valid), 0);

      // Build 5 queued events with overflow set, btn 3 held throughout
      drive(4'b1010, 4'b1010); tick();
      drive(4'b1000, 4'b1000); tick();
      chk("pre_rst_ovf", 32'(overflow), 1);
      drive(4'b0000, 4'b1000); tick();
      drive(4'b0100, 4'b1100); tick();
      drive(4'b0000, 4'b1000); tick();
      drive(4'b0010, 4'b1010); tick();
      drive(4'b0000, 4'b1000); tick();
      drive(4'b0100, 4'b1100); tick();
      drive(4'b0000, 4'b1000); tick();
      chk("pre_rst_count", 32'(evt_count), 5);

      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(evt_valid), 0);
      chk("mid_rst_count", 32'(evt_count), 0);
      chk("mid_rst_ovf",   32'(overflow), 0);
      chk("mid_rst_id",    32'(evt_id), 0);
      chk("mid_rst_rep",   32'(evt_repeat), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (DEB_SETTLE_CYC) tick();
      chk("post_rst_idle", 32'(evt_count), 0);
      drive(4'b1000, 4'b1000); tick();
      drive(4'b0000, 4'b1000); tick();
      chk("post_rst_valid", 32'(evt_valid), 1);
      chk("post_rst_id",    32'(evt_id), 3);
      chk("post_rst_rep",   32'(evt_repeat), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
